// File: rtl/food_coord_latch_pkg.sv
// Shared definitions for the food coordinate path: PIO field layout, screen
// limits, grid size and the latch FSM states. Also used by the food sprite
// and collision blocks.
package food_coord_latch_pkg;

    // 20-bit PIO coordinate layout: X = [19:10], Y = [9:0]
    localparam int COORD_W = 20;
    localparam int FIELD_W = 10;
    localparam int X_LSB   = 10;
    localparam int X_MSB   = 19;
    localparam int Y_LSB   = 0;
    localparam int Y_MSB   = 9;

    // Largest legal food pixel on a 640x480 screen
    localparam int X_MAX_DEF = 639;
    localparam int Y_MAX_DEF = 479;

    // Default grid cell is 16x16 pixels
    localparam int GRID_SHIFT_DEF = 4;

    // Default reject counter width
    localparam int REJ_W_DEF = 8;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        CHECK = 2'd1,
        PEND  = 2'd2,
        SHOWN = 2'd3
    } food_state_e;

    // Clear the low 'shift' bits of a field, snapping it to the grid
    function automatic logic [FIELD_W-1:0] grid_align(
        input logic [FIELD_W-1:0] v,
        input int                 shift
    );
        logic [FIELD_W-1:0] mask;
        mask = {FIELD_W{1'b1}} << shift;
        return v & mask;
    endfunction

endpackage

// File: rtl/food_coord_latch.sv
// Latches the software-written random food coordinate: detects a new value,
// bounds-checks it, snaps it to the grid and only commits it on a frame
// boundary so the food sprite never jumps mid-frame.
module food_coord_latch
    import food_coord_latch_pkg::*;
#(
    parameter int X_MAX      = X_MAX_DEF,
    parameter int Y_MAX      = Y_MAX_DEF,
    parameter int GRID_SHIFT = GRID_SHIFT_DEF,
    parameter int REJ_W      = REJ_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      coord_in,
    input  logic             frame_start,
    input  logic             eaten,
    output logic [9:0]       food_x,
    output logic [9:0]       food_y,
    output logic             food_valid,
    output logic             respawn_req,
    output logic [REJ_W-1:0] reject_cnt
);

    localparam logic [FIELD_W-1:0] X_LIM = FIELD_W'(X_MAX);
    localparam logic [FIELD_W-1:0] Y_LIM = FIELD_W'(Y_MAX);

    food_state_e         state_q, state_d;
    logic [COORD_W-1:0]  snap_q, snap_d;
    logic [COORD_W-1:0]  cand_q, cand_d;
    logic [FIELD_W-1:0]  food_x_q, food_x_d;
    logic [FIELD_W-1:0]  food_y_q, food_y_d;
    logic                food_valid_q, food_valid_d;
    logic                respawn_req_q, respawn_req_d;
    logic [REJ_W-1:0]    reject_cnt_q, reject_cnt_d;

    logic [FIELD_W-1:0]  cand_x, cand_y;
    logic                cand_oob;

    assign cand_x   = cand_q[X_MSB:X_LSB];
    assign cand_y   = cand_q[Y_MSB:Y_LSB];
    assign cand_oob = (cand_x > X_LIM) || (cand_y > Y_LIM);

    // Next-state and datapath updates; every register holds by default
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        cand_d       = cand_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        reject_cnt_d = reject_cnt_q;

        unique case (state_q)
            REQ: begin
                // Change detection only: rewriting the same value is invisible
                if (coord_in != snap_q) begin
                    snap_d  = coord_in;
                    cand_d  = coord_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cand_oob) begin
                    if (reject_cnt_q != {REJ_W{1'b1}})
                        reject_cnt_d = reject_cnt_q + 1'b1;
                    state_d = REQ;
                end else begin
                    cand_d[X_MSB:X_LSB] = grid_align(cand_x, GRID_SHIFT);
                    cand_d[Y_MSB:Y_LSB] = grid_align(cand_y, GRID_SHIFT);
                    state_d = PEND;
                end
            end
            PEND: begin
                // coord_in is ignored here; the checked cand is what commits
                if (frame_start) begin
                    food_x_d     = cand_x;
                    food_y_d     = cand_y;
                    food_valid_d = 1'b1;
                    state_d      = SHOWN;
                end
            end
            SHOWN: begin
                // Re-snapshot coord_in so the stale value is not taken as new
                if (eaten) begin
                    food_valid_d = 1'b0;
                    snap_d       = coord_in;
                    state_d      = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        respawn_req_d = (state_d == REQ);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= REQ;
            snap_q        <= '0;
            cand_q        <= '0;
            food_x_q      <= '0;
            food_y_q      <= '0;
            food_valid_q  <= 1'b0;
            respawn_req_q <= 1'b1;
            reject_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            cand_q        <= cand_d;
            food_x_q      <= food_x_d;
            food_y_q      <= food_y_d;
            food_valid_q  <= food_valid_d;
            respawn_req_q <= respawn_req_d;
            reject_cnt_q  <= reject_cnt_d;
        end
    end

    assign food_x      = food_x_q;
    assign food_y      = food_y_q;
    assign food_valid  = food_valid_q;
    assign respawn_req = respawn_req_q;
    assign reject_cnt  = reject_cnt_q;

endmodule

// File: tb/tb_food_coord_latch.sv
// Self-checking bench for food_coord_latch: directed vector table, corner
// sequences, and randomized transactions against a transaction-level model.
module tb_food_coord_latch;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] coord_in;
    logic        frame_start;
    logic        eaten;
    logic [9:0]  food_x;
    logic [9:0]  food_y;
    logic        food_valid;
    logic        respawn_req;
    logic [7:0]  reject_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: expected reject count and currently committed food
    int exp_rej = 0;
    int exp_fx  = 0;
    int exp_fy  = 0;

    food_coord_latch dut (
        .clk        (clk),
        .reset      (reset),
        .coord_in   (coord_in),
        .frame_start(frame_start),
        .eaten      (eaten),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .respawn_req(respawn_req),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit acc;
        int ex;
        int ey;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int x, input int y);
        logic [9:0] xs, ys;
        xs = 10'(x);
        ys = 10'(y);
        return {xs, ys};
    endfunction

    function automatic int align(input int v);
        return (v / 16) * 16;
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // New value detected on the next edge, checked on the one after
    task automatic write_coord(input logic [19:0] c);
        coord_in = c;
        cyc(2);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_eaten(input bit with_frame);
        eaten = 1'b1;
        frame_start = with_frame;
        cyc(1);
        eaten = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic bump_rej();
        if (exp_rej < 255) exp_rej++;
    endtask

    initial begin
        logic [19:0] cur;
        int x, y, k;
        bit oob;

        tbl[0] = '{x:100, y:200, acc:1, ex:96,  ey:192};
        tbl[1] = '{x:700, y:50,  acc:0, ex:0,   ey:0};
        tbl[2] = '{x:640, y:10,  acc:0, ex:0,   ey:0};
        tbl[3] = '{x:639, y:479, acc:1, ex:624, ey:464};
        tbl[4] = '{x:639, y:480, acc:0, ex:0,   ey:0};
        tbl[5] = '{x:320, y:240, acc:1, ex:320, ey:240};
        tbl[6] = '{x:17,  y:33,  acc:1, ex:16,  ey:32};
        tbl[7] = '{x:0,   y:1023, acc:0, ex:0,  ey:0};

        reset = 1'b1;
        coord_in = '0;
        frame_start = 1'b0;
        eaten = 1'b0;
        cyc(2);
        reset = 1'b0;

        // Idle with coord_in = 0: nothing is detected
        for (int i = 0; i < 4; i++) begin
            cyc(5);
            chk("idle_req", respawn_req, 1);
            chk("idle_valid", food_valid, 0);
            chk("idle_rej", reject_cnt, 0);
        end

        // Directed vectors
        foreach (tbl[i]) begin
            write_coord(mk(tbl[i].x, tbl[i].y));
            if (!tbl[i].acc) begin
                bump_rej();
                chk("tbl_rej_req", respawn_req, 1);
                chk("tbl_rej_cnt", reject_cnt, exp_rej);
                chk("tbl_rej_valid", food_valid, 0);
            end else begin
                chk("tbl_pend_req", respawn_req, 0);
                cyc(10);
                chk("tbl_pre_valid", food_valid, 0);
                chk("tbl_pre_x", food_x, exp_fx);
                pulse_frame();
                exp_fx = tbl[i].ex;
                exp_fy = tbl[i].ey;
                chk("tbl_x", food_x, exp_fx);
                chk("tbl_y", food_y, exp_fy);
                chk("tbl_valid", food_valid, 1);
                chk("tbl_req", respawn_req, 0);
                pulse_eaten(1'b0);
                chk("tbl_eat_valid", food_valid, 0);
                chk("tbl_eat_req", respawn_req, 1);
                chk("tbl_eat_x", food_x, exp_fx);
            end
        end
        cur = mk(tbl[7].x, tbl[7].y);

        // frame_start during CHECK is missed; coord change in PEND ignored
        coord_in = mk(200, 100);
        cyc(1);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        chk("miss_valid", food_valid, 0);
        chk("miss_req", respawn_req, 0);
        coord_in = mk(500, 300);
        cyc(3);
        chk("miss_valid2", food_valid, 0);
        pulse_frame();
        exp_fx = 192;
        exp_fy = 96;
        chk("miss_x", food_x, exp_fx);
        chk("miss_y", food_y, exp_fy);
        chk("miss_commit", food_valid, 1);

        // Eaten with coord_in unchanged: no recommit
        pulse_eaten(1'b0);
        chk("eat_valid", food_valid, 0);
        chk("eat_req", respawn_req, 1);
        cyc(5);
        chk("eat_hold_req", respawn_req, 1);
        chk("eat_hold_valid", food_valid, 0);
        chk("eat_hold_x", food_x, exp_fx);
        write_coord(mk(320, 240));
        pulse_frame();
        exp_fx = 320;
        exp_fy = 240;
        chk("re_x", food_x, exp_fx);
        chk("re_y", food_y, exp_fy);
        chk("re_valid", food_valid, 1);
        pulse_eaten(1'b1);
        chk("eat_wins_valid", food_valid, 0);
        chk("eat_wins_req", respawn_req, 1);
        cur = mk(320, 240);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) x = $urandom_range(640, 1023);
            else x = $urandom_range(0, 639);
            if ($urandom_range(0, 3) == 0) y = $urandom_range(480, 1023);
            else y = $urandom_range(0, 479);
            if (mk(x, y) == cur) y = y ^ 1;
            oob = (x > 639) || (y > 479);
            cur = mk(x, y);
            write_coord(cur);
            if (oob) begin
                bump_rej();
                chk("rnd_rej_req", respawn_req, 1);
                chk("rnd_rej_cnt", reject_cnt, exp_rej);
                continue;
            end
            chk("rnd_pend_req", respawn_req, 0);
            if ($urandom_range(0, 1) == 1) begin
                cur = cur ^ 20'h00400;
                coord_in = cur;
            end
            k = $urandom_range(0, 4);
            cyc(k);
            chk("rnd_pre_valid", food_valid, 0);
            eaten = $urandom_range(0, 1);
            pulse_frame();
            eaten = 1'b0;
            exp_fx = align(x);
            exp_fy = align(y);
            chk("rnd_x", food_x, exp_fx);
            chk("rnd_y", food_y, exp_fy);
            chk("rnd_valid", food_valid, 1);
            chk("rnd_req", respawn_req, 0);
            cyc($urandom_range(0, 3));
            pulse_eaten($urandom_range(0, 1) == 1);
            chk("rnd_eat_valid", food_valid, 0);
            chk("rnd_eat_req", respawn_req, 1);
            chk("rnd_eat_x", food_x, exp_fx);
            chk("rnd_rej_hold", reject_cnt, exp_rej);
        end

        // Saturating reject counter
        for (int i = 0; i < 300; i++) begin
            cur = mk(700 + (i % 300), 0);
            write_coord(cur);
            bump_rej();
        end
        chk("sat_cnt", reject_cnt, 255);
        chk("sat_model", exp_rej, 255);
        chk("sat_req", respawn_req, 1);

        // Reset while in PEND
        write_coord(mk(50, 60));
        chk("pre_rst_req", respawn_req, 0);
        reset = 1'b1;
        coord_in = '0;
        cyc(1);
        reset = 1'b0;
        chk("rst_x", food_x, 0);
        chk("rst_y", food_y, 0);
        chk("rst_valid", food_valid, 0);
        chk("rst_req", respawn_req, 1);
        chk("rst_rej", reject_cnt, 0);
        pulse_frame();
        cyc(3);
        chk("rst_hold_valid", food_valid, 0);
        chk("rst_hold_req", respawn_req, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
